gpu_frame_sequencer: RTL and testbench

Controller in front of GPU_top that owns the vertex-memory write port and the render start/stop handshake. It accepts a vertex word stream from the PS/DMA side and writes it into GPU vertex memory. It then publishes vertex_count, issues a single-cycle start after a settle delay, and waits for frame_end. It reports completion and optionally re-renders the same vertex set continuously.

---
 rtl/gpu_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_gpu_frame_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_frame_sequencer.sv
// gpu_frame_sequencer
// Front-end controller for GPU_top: streams a vertex set into vertex memory,
// publishes the vertex count, fires a start pulse after a settle delay, waits
// for the renderer's frame_end and optionally loops on the same vertex set.
module gpu_frame_sequencer #(
  parameter int M                = 11,
  parameter int N                = 7,
  parameter int VERTEX_MEM_DEPTH = 16384,
  parameter int START_DELAY      = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_load,
  input  logic                                cmd_auto,
  input  logic                                cmd_abort,
  input  logic [M+N-1:0]                      s_data,
  input  logic                                s_valid,
  input  logic                                s_last,
  output logic                                s_ready,
  output logic [$clog2(VERTEX_MEM_DEPTH)-1:0] mem_wr_addr,
  output logic [M+N-1:0]                      mem_wr_data,
  output logic                                mem_wr_en,
  output logic [31:0]                         vertex_count,
  output logic                                start,
  input  logic                                frame_end,
  output logic                                busy,
  output logic                                frame_done,
  output logic [15:0]                         frame_count,
  output logic                                overflow_err
);

  localparam int W  = M + N;
  localparam int AW = $clog2(VERTEX_MEM_DEPTH);
  // Word counter must be able to hold DEPTH itself (saturation value).
  localparam int CW = $clog2(VERTEX_MEM_DEPTH + 1);
  localparam int DW = $clog2(START_DELAY + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(VERTEX_MEM_DEPTH);
  localparam logic [DW-1:0] DELAY_C = DW'(START_DELAY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_START,
    ST_RENDER,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   delay_q, delay_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]    wr_data_q, wr_data_d;
  logic [31:0]     vcount_q, vcount_d;
  logic [15:0]     fcount_q, fcount_d;
  logic            ovf_q, ovf_d;
  logic            fe_q;

  logic            accept;
  logic            fe_rise;
  logic [CW-1:0]   cnt_sat;

  // Stream handshake and renderer edge detect are decoded from registered state.
  assign s_ready = (state_q == ST_LOAD);
  assign accept  = s_valid & s_ready;
  assign fe_rise = frame_end & ~fe_q;
  // Length of the set if the current beat is its last: min(counter+1, DEPTH).
  assign cnt_sat = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + CW'(1);

  // State register plus all datapath registers; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      delay_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      vcount_q  <= '0;
      fcount_q  <= '0;
      ovf_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      delay_q   <= delay_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      vcount_q  <= vcount_d;
      fcount_q  <= fcount_d;
      ovf_q     <= ovf_d;
      fe_q      <= frame_end;
    end
  end

  // Next-state and datapath update; abort overrides everything at the end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    vcount_d  = vcount_q;
    fcount_d  = fcount_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_load) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          if (cnt_q < DEPTH_C) begin
            // Register the beat; it reaches memory one cycle later.
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[AW-1:0];
            wr_data_d = s_data;
            cnt_d     = cnt_q + CW'(1);
          end else begin
            // Set is longer than memory: drop the word, counter stays put.
            ovf_d = 1'b1;
          end
          if (s_last) begin
            state_d  = ST_SETTLE;
            vcount_d = 32'(cnt_sat);
            delay_d  = '0;
          end
        end
      end

      ST_SETTLE: begin
        // The entry cycle is not counted, so the last write has landed
        // START_DELAY cycles before start is raised.
        if (delay_q == DELAY_C) begin
          state_d = ST_START;
        end else begin
          delay_d = delay_q + DW'(1);
        end
      end

      ST_START: begin
        state_d = ST_RENDER;
      end

      ST_RENDER: begin
        // Only a fresh 0->1 seen while rendering ends the frame.
        if (fe_rise) begin
          state_d  = ST_DONE;
          fcount_d = fcount_q + 16'd1;
        end
      end

      ST_DONE: begin
        if (cmd_auto) begin
          state_d = ST_SETTLE;
          delay_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cmd_abort) begin
      // Drop any beat registered this cycle and keep published counters.
      state_d  = ST_IDLE;
      wr_en_d  = 1'b0;
      vcount_d = vcount_q;
      fcount_d = fcount_q;
      ovf_d    = ovf_q;
    end
  end

  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;
  assign vertex_count = vcount_q;
  assign frame_count  = fcount_q;
  assign overflow_err = ovf_q;
  assign start        = (state_q == ST_START);
  assign frame_done   = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Scoreboard bench for gpu_frame_sequencer: stimulus pushes expected memory
// writes, start pulses and frame completions; a negedge monitor pops them.
module tb_gpu_frame_sequencer;

  localparam int M     = 11;
  localparam int N     = 7;
  localparam int W     = M + N;
  localparam int DEPTH = 8;
  localparam int SD    = 6;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_load = 1'b0;
  logic          cmd_auto = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          frame_end = 1'b0;
  logic          s_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [W-1:0]  mem_wr_data;
  logic          mem_wr_en;
  logic [31:0]   vertex_count;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          overflow_err;

  gpu_frame_sequencer #(
    .M(M), .N(N), .VERTEX_MEM_DEPTH(DEPTH), .START_DELAY(SD)
  ) dut (
    .clk(clk), .reset(reset), .cmd_load(cmd_load), .cmd_auto(cmd_auto),
    .cmd_abort(cmd_abort), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .vertex_count(vertex_count), .start(start),
    .frame_end(frame_end), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
  typedef struct { int cycle; logic [31:0] vcount; } start_t;
  typedef struct { int cycle; logic [15:0] fcount; logic [31:0] vcount; } done_t;

  wr_t    exp_wr[$];
  start_t exp_start[$];
  done_t  exp_done[$];

  // Reference model state
  logic [W-1:0] set_words[$];
  logic [31:0]  vcount_m = '0;
  logic [15:0]  fcount_m = '0;
  logic         ovf_m = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t    w;
    start_t s;
    done_t  d;
    if (reset) begin
      if (mem_wr_en) begin
        if (exp_wr.size() == 0) unexpected("wr_unexpected");
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 64'(mem_wr_addr), 64'(w.addr));
          chk("wr_data", 64'(mem_wr_data), 64'(w.data));
        end
      end
      if (start) begin
        if (exp_start.size() == 0) unexpected("start_unexpected");
        else begin
          s = exp_start.pop_front();
          chk("start_cycle", 64'(cyc), 64'(s.cycle));
          chk("start_vcount", 64'(vertex_count), 64'(s.vcount));
        end
      end
      if (frame_done) begin
        if (exp_done.size() == 0) unexpected("done_unexpected");
        else begin
          d = exp_done.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cycle));
          chk("done_fcount", 64'(frame_count), 64'(d.fcount));
          chk("done_vcount", 64'(vertex_count), 64'(d.vcount));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_s_ready"}, 64'(s_ready), 0);
    chk({tag, "_start"}, 64'(start), 0);
    chk({tag, "_frame_done"}, 64'(frame_done), 0);
    chk({tag, "_wr_en"}, 64'(mem_wr_en), 0);
    chk({tag, "_wr_addr"}, 64'(mem_wr_addr), 0);
    chk({tag, "_wr_data"}, 64'(mem_wr_data), 0);
    chk({tag, "_vcount"}, 64'(vertex_count), 0);
    chk({tag, "_fcount"}, 64'(frame_count), 0);
    chk({tag, "_ovf"}, 64'(overflow_err), 0);
  endtask

  // Load set_words; gap_sel<0 gives random 0..2 idle cycles before each beat.
  task automatic load_set(input int gap_sel, output int s_cyc);
    int n, g, c_last;
    n = set_words.size();
    c_last = cyc;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    chk("load_ovf_clear", 64'(overflow_err), 0);
    chk("load_ready", 64'(s_ready), 1);
    for (int i = 0; i < n; i++) begin
      g = (gap_sel < 0) ? int'($urandom_range(0, 2)) : gap_sel;
      for (int k = 0; k < g; k++) begin
        s_valid = 1'b0;
        s_last  = 1'($urandom_range(0, 1));
        s_data  = W'($urandom);
        tick();
      end
      s_valid = 1'b1;
      s_data  = set_words[i];
      s_last  = (i == n - 1);
      if (i < DEPTH) exp_wr.push_back('{addr: AW'(i), data: set_words[i]});
      c_last = cyc;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    vcount_m = (n < DEPTH) ? 32'(n) : 32'(DEPTH);
    ovf_m    = (n > DEPTH);
    chk("load_ready_drop", 64'(s_ready), 0);
    chk("load_ovf", 64'(overflow_err), 64'(ovf_m));
    chk("load_vcount", 64'(vertex_count), 64'(vcount_m));
    s_cyc = c_last + SD + 2;
    exp_start.push_back('{cycle: s_cyc, vcount: vcount_m});
    $display("load: words=%0d gap=%0d vertex_count=%0d overflow=%0b", n, gap_sel, vcount_m, ovf_m);
  endtask

  // Complete one frame whose start is expected at s_cyc.
  task automatic frame(input int s_cyc, input bit pre_high, input bit auto_next, output int next_s);
    int r;
    if (pre_high) begin
      wait_until(s_cyc - 3);
      frame_end = 1'b1;              // rises during SETTLE: must be ignored
      wait_until(s_cyc - 2);
      cmd_load = 1'b1;               // not IDLE: must be ignored
      tick();
      cmd_load = 1'b0;
      wait_until(s_cyc + 2);
      frame_end = 1'b0;
      r = s_cyc + 4;
    end else begin
      r = s_cyc + 3;
    end
    wait_until(r);
    frame_end = 1'b1;
    cmd_auto  = auto_next;
    fcount_m  = fcount_m + 16'd1;
    exp_done.push_back('{cycle: r + 1, fcount: fcount_m, vcount: vcount_m});
    next_s = -1;
    if (auto_next) begin
      next_s = r + SD + 3;
      exp_start.push_back('{cycle: next_s, vcount: vcount_m});
    end
    tick();
    tick();
    frame_end = 1'b0;
    $display("frame: pre_high=%0b auto=%0b frame_count=%0d", pre_high, auto_next, fcount_m);
  endtask

  initial begin
    int s, nx, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 0);
    chk("idle_ready", 64'(s_ready), 0);

    // Five-word set, valid held high
    set_words = '{W'(10), W'(-3), W'(7), W'(0), W'(127)};
    load_set(0, s);
    frame(s, 1'b0, 1'b0, nx);

    // One beat in every three cycles
    set_words = '{W'(5), W'(-100), W'(2047), W'(-2048), W'(1), W'(77)};
    load_set(2, s);
    frame(s, 1'b0, 1'b0, nx);

    // frame_end already high before start; only the in-RENDER edge counts
    set_words = '{W'(1), W'(2), W'(3)};
    load_set(0, s);
    frame(s, 1'b1, 1'b0, nx);

    // Continuous re-render: three starts, three frames, no reload
    set_words = '{W'(9), W'(8), W'(7), W'(6)};
    load_set(1, s);
    frame(s, 1'b0, 1'b1, s);
    frame(s, 1'b1, 1'b1, s);
    frame(s, 1'b0, 1'b0, nx);

    // Overflow: 10 words into 8-deep memory
    set_words.delete();
    for (int i = 0; i < 10; i++) set_words.push_back(W'(i * 3 + 1));
    load_set(0, s);
    frame(s, 1'b0, 1'b0, nx);

    // Exactly full, then randomized sets (next load clears overflow)
    set_words.delete();
    for (int i = 0; i < DEPTH; i++) set_words.push_back(W'($urandom));
    load_set(-1, s);
    frame(s, 1'b0, 1'b0, nx);
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 11));
      set_words.delete();
      for (int i = 0; i < n; i++) set_words.push_back(W'($urandom));
      load_set(-1, s);
      frame(s, 1'($urandom_range(0, 1)), 1'b0, nx);
    end

    // Abort mid-LOAD, on the s_last beat: that write is dropped
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_last  = 1'b0;
      s_data  = W'($urandom);
      exp_wr.push_back('{addr: AW'(i), data: s_data});
      tick();
    end
    s_data    = W'($urandom);
    s_last    = 1'b1;
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("abort_load_busy", 64'(busy), 0);
    chk("abort_load_ready", 64'(s_ready), 0);
    chk("abort_load_wr_en", 64'(mem_wr_en), 0);
    chk("abort_load_vcount", 64'(vertex_count), 64'(vcount_m));
    repeat (4) begin
      s_data = W'($urandom);
      s_last = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    $display("abort: during LOAD");
    repeat (SD + 6) tick();

    // Abort in RENDER; a later frame_end edge must not complete a frame
    set_words = '{W'(11), W'(22), W'(33), W'(44)};
    load_set(0, s);
    wait_until(s + 3);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("abort_render_busy", 64'(busy), 0);
    chk("abort_render_fcount", 64'(frame_count), 64'(fcount_m));
    chk("abort_render_vcount", 64'(vertex_count), 64'(vcount_m));
    tick();
    tick();
    frame_end = 1'b1;
    tick();
    tick();
    frame_end = 1'b0;
    $display("abort: during RENDER");
    repeat (SD + 6) tick();

    // Async reset mid-RENDER with overflow set: outputs clear before any edge
    set_words.delete();
    for (int i = 0; i < 9; i++) set_words.push_back(W'($urandom));
    load_set(0, s);
    wait_until(s + 3);
    #2;
    reset = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    vcount_m = '0;
    fcount_m = '0;
    ovf_m    = 1'b0;
    tick();
    tick();
    #3;
    reset = 1'b1;
    tick();
    $display("reset: asserted during RENDER");

    // Frame count restarts after reset
    set_words = '{W'(-1), W'(42)};
    load_set(0, s);
    frame(s, 1'b0, 1'b0, nx);

    repeat (SD + 10) tick();
    chk("sb_wr_left", 64'(exp_wr.size()), 0);
    chk("sb_start_left", 64'(exp_start.size()), 0);
    chk("sb_done_left", 64'(exp_done.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
